// File: rtl/vdc_pkg.sv
// Shared types and constants for the VDC RAM slot scheduler.
// The optional refresh engine is built only when VDC_REFRESH_EN is defined.
package vdc_pkg;

    localparam int WC_ZERO_COUNT = 256;
    localparam int COUNT_BITS    = 9;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        RD_WAIT,
        CP_RD,
        CP_WR,
        FILL
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_FETCH,
        GNT_REFRESH,
        GNT_CPU
    } gnt_t;

    function automatic logic [COUNT_BITS-1:0] load_count(input logic [7:0] wc);
        return (wc == 8'h00) ? COUNT_BITS'(WC_ZERO_COUNT) : {1'b0, wc};
    endfunction

endpackage

// File: rtl/vdc_ram_sched_if.sv
// VDC RAM bus: the scheduler is the master, the RAM (synchronous, one-cycle read) is the slave.
interface vdc_ram_sched_if;

    logic [15:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    modport master (output ram_addr, ram_we, ram_wdata, input ram_rdata);
    modport slave  (input ram_addr, ram_we, ram_wdata, output ram_rdata);

endinterface

// File: rtl/vdc_refresh_ctr.sv
// Per-line refresh budget and refresh row address; requests a slot while budget remains.
module vdc_refresh_ctr (
    input  logic       clk,
    input  logic       reset,
    input  logic       refresh_start,
    input  logic [3:0] reg_drr,
    input  logic       grant,
    output logic       req,
    output logic [7:0] row
);

    logic [3:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 4'd0;
            row   <= 8'h00;
        end else begin
            if (refresh_start) begin
                count <= reg_drr;
            end else if (grant) begin
                count <= count - 4'd1;
            end
            if (grant) begin
                row <= row + 8'd1;
            end
        end
    end

    assign req = (count != 4'd0);

endmodule

// File: rtl/vdc_ram_sched.sv
// VDC RAM slot scheduler: fetch > refresh > CPU/block per enabled slot; CPU R31 access, block copy/fill.
// Refresh logic is present only when VDC_REFRESH_EN is defined.
module vdc_ram_sched
    import vdc_pkg::*;
#(
    parameter int RAM_ADDR_BITS = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  mask16k,
    input  logic                  fetch_req,
    input  logic [15:0]           fetch_addr,
    input  logic                  refresh_start,
    input  logic [3:0]            reg_drr,
    input  logic                  cpu_wr,
    input  logic                  cpu_rd,
    input  logic [7:0]            cpu_data,
    input  logic                  ua_load,
    input  logic [15:0]           ua_in,
    input  logic                  ba_load,
    input  logic [15:0]           ba_in,
    input  logic                  wc_start,
    input  logic [7:0]            wc_in,
    input  logic                  reg_copy,
    vdc_ram_sched_if.master       ram,
    output logic                  fetch_ack,
    output logic [15:0]           reg_ua,
    output logic [15:0]           reg_ba,
    output logic [7:0]            reg_da,
    output logic                  busy
);

    localparam logic [15:0] PHYS_MASK = 16'((32'd1 << RAM_ADDR_BITS) - 32'd1);

    state_t                state, state_next;
    gnt_t                  gnt;
    logic [COUNT_BITS-1:0] count;
    logic [15:0]           addr_q, slot_addr, out_addr;
    logic [7:0]            wdata_q, slot_wdata;
    logic                  slot_we;
    logic                  cpu_req, cpu_gnt;
    logic                  refresh_req, refresh_gnt;
    logic [7:0]            refresh_row;
    logic                  cap_pending;
    logic [7:0]            cp_byte, copy_byte;

    assign refresh_gnt = (gnt == GNT_REFRESH);

`ifdef VDC_REFRESH_EN
    vdc_refresh_ctr u_refresh (
        .clk           (clk),
        .reset         (reset),
        .refresh_start (refresh_start),
        .reg_drr       (reg_drr),
        .grant         (refresh_gnt),
        .req           (refresh_req),
        .row           (refresh_row)
    );
`else
    logic unused_refresh;
    assign refresh_req    = 1'b0;
    assign refresh_row    = 8'h00;
    assign unused_refresh = ^{refresh_start, reg_drr, refresh_gnt};
`endif

    assign busy    = (state != IDLE);
    assign cpu_req = (state inside {WR, RD, CP_RD, CP_WR, FILL});
    assign cpu_gnt = (gnt == GNT_CPU);

    // The copied byte is captured the cycle after its read; until then it comes straight off the bus.
    assign copy_byte = cap_pending ? ram.ram_rdata : cp_byte;

    always_comb begin
        gnt = GNT_NONE;
        if (enable && !reset) begin
            if (fetch_req)        gnt = GNT_FETCH;
            else if (refresh_req) gnt = GNT_REFRESH;
            else if (cpu_req)     gnt = GNT_CPU;
        end
    end

    // NOTE: every signal gets a default first so no path through the case leaves a latch behind.
    always_comb begin
        slot_addr  = addr_q;
        slot_we    = 1'b0;
        slot_wdata = wdata_q;
        state_next = state;
        unique case (gnt)
            GNT_FETCH:   slot_addr = fetch_addr;
            GNT_REFRESH: slot_addr = {8'h00, refresh_row};
            GNT_CPU: begin
                unique case (state)
                    WR, FILL: begin
                        slot_addr  = reg_ua;
                        slot_we    = 1'b1;
                        slot_wdata = reg_da;
                    end
                    RD:    slot_addr = reg_ua;
                    CP_RD: slot_addr = reg_ba;
                    CP_WR: begin
                        slot_addr  = reg_ua;
                        slot_we    = 1'b1;
                        slot_wdata = copy_byte;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase

        unique case (state)
            IDLE: begin
                if (cpu_wr)        state_next = WR;
                else if (cpu_rd)   state_next = RD;
                else if (wc_start) state_next = reg_copy ? CP_RD : FILL;
            end
            WR:      if (cpu_gnt) state_next = IDLE;
            RD:      if (cpu_gnt) state_next = RD_WAIT;
            RD_WAIT: if (enable)  state_next = IDLE;
            CP_RD:   if (cpu_gnt) state_next = CP_WR;
            CP_WR:   if (cpu_gnt) state_next = (count == COUNT_BITS'(1)) ? IDLE : CP_RD;
            FILL:    if (cpu_gnt && count == COUNT_BITS'(1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        out_addr = slot_addr & PHYS_MASK;
        if (mask16k) out_addr[15:14] = 2'b00;
    end

    assign ram.ram_addr  = out_addr;
    assign ram.ram_we    = slot_we;
    assign ram.ram_wdata = slot_wdata;
    assign fetch_ack     = (gnt == GNT_FETCH);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            reg_ua      <= 16'h0000;
            reg_ba      <= 16'h0000;
            reg_da      <= 8'h00;
            count       <= '0;
            addr_q      <= 16'h0000;
            wdata_q     <= 8'h00;
            cap_pending <= 1'b0;
            cp_byte     <= 8'h00;
        end else begin
            state       <= state_next;
            cap_pending <= cpu_gnt && (state == CP_RD);
            if (gnt != GNT_NONE) addr_q  <= slot_addr;
            if (slot_we)         wdata_q <= slot_wdata;
            if (cap_pending)     cp_byte <= ram.ram_rdata;

            unique case (state)
                IDLE: begin
                    if (ua_load) reg_ua <= ua_in;
                    if (ba_load) reg_ba <= ba_in;
                    if (cpu_wr) reg_da <= cpu_data;
                    else if (!cpu_rd && wc_start) count <= load_count(wc_in);
                end
                WR: if (cpu_gnt) reg_ua <= reg_ua + 16'd1;
                RD_WAIT: begin
                    if (enable) begin
                        reg_da <= ram.ram_rdata;
                        reg_ua <= reg_ua + 16'd1;
                    end
                end
                CP_WR: begin
                    if (cpu_gnt) begin
                        reg_da <= copy_byte;
                        reg_ba <= reg_ba + 16'd1;
                        reg_ua <= reg_ua + 16'd1;
                        count  <= count - COUNT_BITS'(1);
                    end
                end
                FILL: begin
                    if (cpu_gnt) begin
                        reg_ua <= reg_ua + 16'd1;
                        count  <= count - COUNT_BITS'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vdc_ram_sched.sv
// Scoreboard bench for vdc_ram_sched: expected RAM slots are queued by the stimulus, checked by a monitor.
module tb_vdc_ram_sched;

    logic        clk = 1'b0;
    logic        reset, enable, mask16k, fetch_req;
    logic [15:0] fetch_addr;
    logic        refresh_start;
    logic [3:0]  reg_drr;
    logic        cpu_wr, cpu_rd;
    logic [7:0]  cpu_data;
    logic        ua_load, ba_load, wc_start, reg_copy;
    logic [15:0] ua_in, ba_in;
    logic [7:0]  wc_in;
    logic        fetch_ack, busy;
    logic [15:0] reg_ua, reg_ba;
    logic [7:0]  reg_da;

    always #5 clk = ~clk;

    vdc_ram_sched_if ram_bus ();

    vdc_ram_sched #(.RAM_ADDR_BITS(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .mask16k       (mask16k),
        .fetch_req     (fetch_req),
        .fetch_addr    (fetch_addr),
        .refresh_start (refresh_start),
        .reg_drr       (reg_drr),
        .cpu_wr        (cpu_wr),
        .cpu_rd        (cpu_rd),
        .cpu_data      (cpu_data),
        .ua_load       (ua_load),
        .ua_in         (ua_in),
        .ba_load       (ba_load),
        .ba_in         (ba_in),
        .wc_start      (wc_start),
        .wc_in         (wc_in),
        .reg_copy      (reg_copy),
        .ram           (ram_bus),
        .fetch_ack     (fetch_ack),
        .reg_ua        (reg_ua),
        .reg_ba        (reg_ba),
        .reg_da        (reg_da),
        .busy          (busy)
    );

    // Synchronous RAM with one-cycle read latency.
    logic [7:0] mem [0:65535];
    always @(posedge clk) begin
        ram_bus.ram_rdata <= mem[ram_bus.ram_addr];
        if (ram_bus.ram_we) mem[ram_bus.ram_addr] <= ram_bus.ram_wdata;
    end

    typedef struct packed {
        logic        ack;
        logic        we;
        logic [15:0] addr;
        logic [7:0]  data;
    } slot_t;

    slot_t exp_wr[$];
    slot_t exp_slot[$];
    slot_t mon_e;
    bit    slot_watch = 1'b0;
    int    checks = 0;
    int    failures = 0;

    function automatic slot_t mk(logic ack, logic we, logic [15:0] addr, logic [7:0] data);
        slot_t s;
        s.ack  = ack;
        s.we   = we;
        s.addr = addr;
        s.data = data;
        return s;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: in slot-trace mode every enabled cycle is compared; otherwise every write strobe.
    always @(negedge clk) begin
        if (slot_watch) begin
            if (enable) begin
                if (exp_slot.size() == 0) begin
                    check("slot_extra", {30'd0, ram_bus.ram_we, fetch_ack}, 32'd0);
                end else begin
                    mon_e = exp_slot.pop_front();
                    check("slot_ack", fetch_ack, mon_e.ack);
                    check("slot_we", ram_bus.ram_we, mon_e.we);
                    check("slot_addr", ram_bus.ram_addr, mon_e.addr);
                    if (mon_e.we) check("slot_wdata", ram_bus.ram_wdata, mon_e.data);
                end
            end
        end else if (ram_bus.ram_we) begin
            if (exp_wr.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                         ram_bus.ram_addr, ram_bus.ram_wdata);
            end else begin
                mon_e = exp_wr.pop_front();
                check("wr_addr", ram_bus.ram_addr, mon_e.addr);
                check("wr_data", ram_bus.ram_wdata, mon_e.data);
                check("wr_ack", fetch_ack, 1'b0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pulses();
        cpu_wr        = 1'b0;
        cpu_rd        = 1'b0;
        ua_load       = 1'b0;
        ba_load       = 1'b0;
        wc_start      = 1'b0;
        refresh_start = 1'b0;
    endtask

    task automatic wait_idle(string name, int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check({name, "_idle"}, busy, 1'b0);
    endtask

    task automatic wait_slots(string name, int budget);
        int n = 0;
        while (exp_slot.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check({name, "_slots_left"}, exp_slot.size(), 0);
        slot_watch = 1'b0;
        enable     = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; enable = 1'b0; mask16k = 1'b0; fetch_req = 1'b0; fetch_addr = 16'h0000;
        reg_drr = 4'd0; cpu_data = 8'h00; ua_in = 16'h0000; ba_in = 16'h0000;
        wc_in = 8'h00; reg_copy = 1'b0;
        clear_pulses();
        mem[16'h2000] = 8'h11;
        mem[16'h2001] = 8'h22;
        mem[16'h2002] = 8'h33;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state
        check("rst_busy", busy, 1'b0);
        check("rst_ua", reg_ua, 16'h0000);
        check("rst_ba", reg_ba, 16'h0000);
        check("rst_da", reg_da, 8'h00);
        check("rst_addr", ram_bus.ram_addr, 16'h0000);
        check("rst_we", ram_bus.ram_we, 1'b0);
        check("rst_wdata", ram_bus.ram_wdata, 8'h00);
        check("rst_ack", fetch_ack, 1'b0);

        // Single CPU write; ua_load and cpu_wr coincide so the write targets the new address
        enable = 1'b1;
        ua_load = 1'b1; ua_in = 16'h1000; cpu_wr = 1'b1; cpu_data = 8'h5A;
        exp_wr.push_back(mk(1'b0, 1'b1, 16'h1000, 8'h5A));
        tick();
        clear_pulses();
        wait_idle("wr", 20);
        check("wr_ua", reg_ua, 16'h1001);
        check("wr_da", reg_da, 8'h5A);
        check("wr_q", exp_wr.size(), 0);

        // Refresh budget of 5 ahead of a pending CPU write
        enable = 1'b0;
        ua_load = 1'b1; ua_in = 16'h0100;
        tick();
        clear_pulses();
        refresh_start = 1'b1; reg_drr = 4'd5; cpu_wr = 1'b1; cpu_data = 8'h77;
        tick();
        clear_pulses();
`ifdef VDC_REFRESH_EN
        for (int i = 0; i < 5; i++) exp_slot.push_back(mk(1'b0, 1'b0, 16'h0000 + 16'(i), 8'h00));
`endif
        exp_slot.push_back(mk(1'b0, 1'b1, 16'h0100, 8'h77));
        slot_watch = 1'b1;
        enable = 1'b1;
        wait_slots("refresh", 30);
        wait_idle("refresh", 20);
        check("refresh_ua", reg_ua, 16'h0101);

        // 16K masking of the bus address only
        enable = 1'b1; mask16k = 1'b1;
        ua_load = 1'b1; ua_in = 16'hC010; cpu_wr = 1'b1; cpu_data = 8'h3C;
        exp_wr.push_back(mk(1'b0, 1'b1, 16'h0010, 8'h3C));
        tick();
        clear_pulses();
        wait_idle("mask", 20);
        check("mask_ua", reg_ua, 16'hC011);
        mask16k = 1'b0;

        // Block copy of 3 bytes; loads and CPU pulses while busy are ignored
        enable = 1'b0;
        ba_load = 1'b1; ba_in = 16'h2000; ua_load = 1'b1; ua_in = 16'h3000;
        tick();
        clear_pulses();
        wc_start = 1'b1; wc_in = 8'd3; reg_copy = 1'b1;
        tick();
        clear_pulses();
        ua_load = 1'b1; ua_in = 16'h7777; ba_load = 1'b1; ba_in = 16'h1111;
        cpu_wr = 1'b1; cpu_data = 8'hEE;
        tick();
        clear_pulses();
        exp_wr.push_back(mk(1'b0, 1'b1, 16'h3000, 8'h11));
        exp_wr.push_back(mk(1'b0, 1'b1, 16'h3001, 8'h22));
        exp_wr.push_back(mk(1'b0, 1'b1, 16'h3002, 8'h33));
        enable = 1'b1;
        wait_idle("copy", 50);
        check("copy_ba", reg_ba, 16'h2003);
        check("copy_ua", reg_ua, 16'h3003);
        check("copy_da", reg_da, 8'h33);
        check("copy_q", exp_wr.size(), 0);

        // CPU read of a byte the copy wrote
        ua_load = 1'b1; ua_in = 16'h3001; cpu_rd = 1'b1;
        tick();
        clear_pulses();
        wait_idle("rd", 20);
        check("rd_da", reg_da, 8'h22);
        check("rd_ua", reg_ua, 16'h3002);

        // Fill of 256 bytes (wc=0) wrapping through 0x0000
        cpu_wr = 1'b1; cpu_data = 8'hFF; ua_load = 1'b1; ua_in = 16'h9000;
        exp_wr.push_back(mk(1'b0, 1'b1, 16'h9000, 8'hFF));
        tick();
        clear_pulses();
        wait_idle("da_ff", 20);
        ua_load = 1'b1; ua_in = 16'hFFFE; wc_start = 1'b1; wc_in = 8'h00; reg_copy = 1'b0;
        for (int i = 0; i < 256; i++) exp_wr.push_back(mk(1'b0, 1'b1, 16'hFFFE + 16'(i), 8'hFF));
        tick();
        clear_pulses();
        wait_idle("fill256", 300);
        check("fill256_ua", reg_ua, 16'h00FE);
        check("fill256_q", exp_wr.size(), 0);

        // Fetch held across a 4-byte fill: fetch owns every slot until it drops
        enable = 1'b0;
        ua_load = 1'b1; ua_in = 16'h6000; wc_start = 1'b1; wc_in = 8'd4; reg_copy = 1'b0;
        tick();
        clear_pulses();
        for (int i = 0; i < 6; i++) exp_slot.push_back(mk(1'b1, 1'b0, 16'h4000 + 16'(i), 8'h00));
        for (int i = 0; i < 4; i++) exp_slot.push_back(mk(1'b0, 1'b1, 16'h6000 + 16'(i), 8'hFF));
        slot_watch = 1'b1;
        enable = 1'b1;
        fetch_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            fetch_addr = 16'h4000 + 16'(i);
            tick();
        end
        fetch_req = 1'b0;
        wait_slots("fetch", 30);
        wait_idle("fetch", 20);
        check("fetch_ua", reg_ua, 16'h6004);

        // Reset in the middle of a 100-byte fill
        ua_load = 1'b1; ua_in = 16'h8000; wc_start = 1'b1; wc_in = 8'd100; reg_copy = 1'b0;
        tick();
        clear_pulses();
        for (int i = 0; i < 100; i++) exp_wr.push_back(mk(1'b0, 1'b1, 16'h8000 + 16'(i), 8'hFF));
        enable = 1'b1;
        repeat (10) tick();
        check("pre_rst_q", exp_wr.size(), 90);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_wr.delete();
        check("midrst_busy", busy, 1'b0);
        check("midrst_we", ram_bus.ram_we, 1'b0);
        check("midrst_ua", reg_ua, 16'h0000);
        check("midrst_da", reg_da, 8'h00);
        check("midrst_addr", ram_bus.ram_addr, 16'h0000);
        repeat (20) tick();
        check("post_rst_busy", busy, 1'b0);
        enable = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
